// File: rtl/msg_store_fwd_fifo.sv
// Store-and-forward message buffer: only fully written messages are presented downstream.
// A message that overflows the buffer, or is cut short by a new sop, is discarded whole.
module msg_store_fwd_fifo #(
    parameter int DATA_W  = 64,
    parameter int EMPTY_W = 3,
    parameter int DEPTH   = 16,
    parameter int CNT_W   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_W-1:0]          i_msg_in_data,
    input  logic [EMPTY_W-1:0]         i_msg_in_empty,
    input  logic                       i_msg_in_sop,
    input  logic                       i_msg_in_eop,
    input  logic                       i_msg_in_valid,
    output logic                       o_msg_in_ready,
    output logic [DATA_W-1:0]          o_msg_out_data,
    output logic [EMPTY_W-1:0]         o_msg_out_empty,
    output logic                       o_msg_out_sop,
    output logic                       o_msg_out_eop,
    output logic                       o_msg_out_valid,
    input  logic                       i_msg_out_ready,
    output logic                       o_drop_pulse,
    output logic [CNT_W-1:0]           o_drop_cnt,
    output logic [$clog2(DEPTH):0]     o_level
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;
    localparam int ENT_W = DATA_W + EMPTY_W + 2;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_STORE   = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    logic [ENT_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_commit;
    state_t           r_state;
    logic             r_drop_pulse;
    logic [CNT_W-1:0] r_drop_cnt;

    state_t           w_next_state;
    state_t           w_start_state;
    logic             w_acc;
    logic             w_full;
    logic             w_commit_full;
    logic             w_start;
    logic             w_overflow;
    logic             w_abort;
    logic             w_wr_en;
    logic [PTR_W-1:0] w_wr_addr;
    logic [PTR_W-1:0] w_wr_ptr_nxt;
    logic [PTR_W-1:0] w_commit_nxt;
    logic             w_drop;
    logic             w_rd_en;
    logic [ENT_W-1:0] w_rd_entry;

    assign o_msg_in_ready = ~rst;
    assign w_acc          = i_msg_in_valid & o_msg_in_ready;
    // Occupancy uses the registered read pointer: a same-cycle read frees nothing.
    assign w_full         = ((r_wr_ptr - r_rd_ptr) == PTR_W'(DEPTH));
    assign w_commit_full  = ((r_wr_commit - r_rd_ptr) == PTR_W'(DEPTH));
    assign w_start_state  = i_msg_in_eop ? S_IDLE : (w_commit_full ? S_DISCARD : S_STORE);

    assign o_msg_out_valid = (r_rd_ptr != r_wr_commit);
    assign w_rd_en         = o_msg_out_valid & i_msg_out_ready;
    assign w_rd_entry      = r_mem[r_rd_ptr[AW-1:0]];
    assign o_msg_out_data  = w_rd_entry[ENT_W-1 -: DATA_W];
    assign o_msg_out_empty = w_rd_entry[EMPTY_W+1:2];
    assign o_msg_out_sop   = w_rd_entry[1];
    assign o_msg_out_eop   = w_rd_entry[0];
    assign o_level         = r_wr_commit - r_rd_ptr;
    assign o_drop_pulse    = r_drop_pulse;
    assign o_drop_cnt      = r_drop_cnt;

    // State, pointer and drop-statistics registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_wr_commit  <= '0;
            r_drop_pulse <= 1'b0;
            r_drop_cnt   <= '0;
        end else begin
            r_state      <= w_next_state;
            r_wr_ptr     <= w_wr_ptr_nxt;
            r_wr_commit  <= w_commit_nxt;
            r_drop_pulse <= w_drop;
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_drop && (r_drop_cnt != {CNT_W{1'b1}})) begin
                r_drop_cnt <= r_drop_cnt + CNT_W'(1);
            end
        end
    end

    // Beat storage; contents need no reset since pointers gate visibility.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr[AW-1:0]] <= {i_msg_in_data, i_msg_in_empty, i_msg_in_sop, i_msg_in_eop};
        end
    end

    // Next-state logic and classification of the accepted beat.
    always_comb begin
        w_next_state = r_state;
        w_start      = 1'b0;
        w_overflow   = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_acc && i_msg_in_sop) begin
                    w_start      = 1'b1;
                    w_next_state = w_start_state;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_STORE: begin
                if (!w_acc) begin
                    w_next_state = S_STORE;
                end else if (w_full) begin
                    w_overflow   = 1'b1;
                    w_next_state = i_msg_in_eop ? S_IDLE : S_DISCARD;
                end else if (i_msg_in_sop) begin
                    // Rewinding leaves less than a full buffer, so the restart cannot also overflow.
                    w_abort      = 1'b1;
                    w_start      = 1'b1;
                    w_next_state = w_start_state;
                end else if (i_msg_in_eop) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_STORE;
                end
            end
            S_DISCARD: begin
                if (w_acc && i_msg_in_sop) begin
                    w_start      = 1'b1;
                    w_next_state = w_start_state;
                end else if (w_acc && i_msg_in_eop) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_DISCARD;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Write-side datapath: memory write, pointer advance, commit and drop.
    always_comb begin
        w_wr_en      = 1'b0;
        w_wr_addr    = r_wr_ptr;
        w_wr_ptr_nxt = r_wr_ptr;
        w_commit_nxt = r_wr_commit;
        w_drop       = w_overflow | w_abort;
        if (w_start) begin
            if (w_commit_full) begin
                w_drop       = 1'b1;
                w_wr_ptr_nxt = r_wr_commit;
            end else begin
                w_wr_en      = 1'b1;
                w_wr_addr    = r_wr_commit;
                w_wr_ptr_nxt = r_wr_commit + PTR_W'(1);
                if (i_msg_in_eop) begin
                    w_commit_nxt = r_wr_commit + PTR_W'(1);
                end else begin
                    w_commit_nxt = r_wr_commit;
                end
            end
        end else if (w_overflow) begin
            w_wr_ptr_nxt = r_wr_commit;
        end else if ((r_state == S_STORE) && w_acc) begin
            w_wr_en      = 1'b1;
            w_wr_ptr_nxt = r_wr_ptr + PTR_W'(1);
            if (i_msg_in_eop) begin
                w_commit_nxt = r_wr_ptr + PTR_W'(1);
            end else begin
                w_commit_nxt = r_wr_commit;
            end
        end else begin
            w_wr_en = 1'b0;
        end
    end

endmodule
